// File: rtl/lc3_pkg.sv
// Purpose : shared encodings for the LC-3 control unit (opcodes, FSM states, mux selects, control word).
// Latency : n/a (constants and types only).
// Backpressure: n/a.
package lc3_pkg;

    // Opcodes (IR[15:12]) of the supported subset
    localparam logic [3:0] OP_BR  = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_NOT = 4'b1001;
    localparam logic [3:0] OP_JMP = 4'b1100;
    localparam logic [3:0] OP_LEA = 4'b1110;

    // FSM states
    localparam logic [3:0] S_FETCH0   = 4'd0;
    localparam logic [3:0] S_FETCH1   = 4'd1;
    localparam logic [3:0] S_FETCH2   = 4'd2;
    localparam logic [3:0] S_DECODE   = 4'd3;
    localparam logic [3:0] S_EXEC_ALU = 4'd4;
    localparam logic [3:0] S_BR       = 4'd5;
    localparam logic [3:0] S_JMP      = 4'd6;
    localparam logic [3:0] S_LEA      = 4'd7;
    localparam logic [3:0] S_ADDR     = 4'd8;
    localparam logic [3:0] S_MEMRD    = 4'd9;
    localparam logic [3:0] S_LOADREG  = 4'd10;
    localparam logic [3:0] S_STMDR    = 4'd11;
    localparam logic [3:0] S_MEMWR    = 4'd12;
    localparam logic [3:0] S_HALT     = 4'd13;

    // PC mux
    localparam logic [1:0] SELPC_INC = 2'b00;
    localparam logic [1:0] SELPC_EAB = 2'b01;
    localparam logic [1:0] SELPC_BUS = 2'b10;

    // EAB offset mux
    localparam logic [1:0] EAB2_ZERO  = 2'b00;
    localparam logic [1:0] EAB2_OFF6  = 2'b01;
    localparam logic [1:0] EAB2_OFF9  = 2'b10;
    localparam logic [1:0] EAB2_OFF11 = 2'b11;

    // ALU function
    localparam logic [1:0] ALUK_ADD   = 2'b00;
    localparam logic [1:0] ALUK_AND   = 2'b01;
    localparam logic [1:0] ALUK_NOT   = 2'b10;
    localparam logic [1:0] ALUK_PASSA = 2'b11;

    // Full control word produced by the output decode each cycle
    typedef struct packed {
        logic       ldMAR;
        logic       ldMDR;
        logic       ldIR;
        logic       ldPC;
        logic       ldREG;
        logic       ldCC;
        logic       gatePC;
        logic       gateMDR;
        logic       gateALU;
        logic       gateMARMUX;
        logic [1:0] selPC;
        logic       selEAB1;
        logic [1:0] selEAB2;
        logic       SR1sel;
        logic [1:0] aluK;
        logic       memEn;
        logic       memWE;
        logic       halted;
    } ctrl_t;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LD) || (op == OP_LDR);
    endfunction

endpackage

// File: rtl/lc3_control_if.sv
// Purpose : bundle between LC-3 control unit (master) and datapath/memory (slave).
// Latency : n/a (wires only).
// Backpressure: memReady from the slave stretches memory states; nothing else stalls.
interface lc3_control_if;
    logic [15:0] IR;
    logic        N, Z, P;
    logic        memReady;
    logic        ldMAR, ldMDR, ldIR, ldPC, ldREG, ldCC;
    logic        gatePC, gateMDR, gateALU, gateMARMUX;
    logic [1:0]  selPC;
    logic        selEAB1;
    logic [1:0]  selEAB2;
    logic        SR1sel;
    logic [1:0]  aluK;
    logic        memEn, memWE;
    logic        halted;

    modport master (
        input  IR, N, Z, P, memReady,
        output ldMAR, ldMDR, ldIR, ldPC, ldREG, ldCC,
        output gatePC, gateMDR, gateALU, gateMARMUX,
        output selPC, selEAB1, selEAB2, SR1sel, aluK,
        output memEn, memWE, halted
    );

    modport slave (
        output IR, N, Z, P, memReady,
        input  ldMAR, ldMDR, ldIR, ldPC, ldREG, ldCC,
        input  gatePC, gateMDR, gateALU, gateMARMUX,
        input  selPC, selEAB1, selEAB2, SR1sel, aluK,
        input  memEn, memWE, halted
    );
endinterface

// File: rtl/lc3_ctrl_decode.sv
// Purpose : combinational control-word decode from (state, IR[15:9], NZP, memReady, reset).
// Latency : 0 cycles, purely combinational.
// Backpressure: ldMDR follows memReady in memory-read waits; no storage here.
// Ports   : i_rst_n (zeroes everything while low), i_state, i_ir_hi = IR[15:9],
//           i_n/i_z/i_p flags, i_mem_ready, o_ctrl control word.
module lc3_ctrl_decode
    import lc3_pkg::*;
(
    input  logic        i_rst_n,
    input  logic [3:0]  i_state,
    input  logic [15:9] i_ir_hi,
    input  logic        i_n,
    input  logic        i_z,
    input  logic        i_p,
    input  logic        i_mem_ready,
    output ctrl_t       o_ctrl
);
    logic [3:0] w_op;
    assign w_op = i_ir_hi[15:12];

    always_comb begin
        o_ctrl = '0;
        // Reset overrides the FETCH0 decode so nothing is loaded while held.
        if (i_rst_n) begin
            case (i_state)
                S_FETCH0: begin
                    o_ctrl.gatePC = 1'b1;
                    o_ctrl.ldMAR  = 1'b1;
                    o_ctrl.ldPC   = 1'b1;
                    o_ctrl.selPC  = SELPC_INC;
                end
                S_FETCH1, S_MEMRD: begin
                    o_ctrl.memEn = 1'b1;
                    o_ctrl.ldMDR = i_mem_ready;
                end
                S_FETCH2: begin
                    o_ctrl.gateMDR = 1'b1;
                    o_ctrl.ldIR    = 1'b1;
                end
                S_EXEC_ALU: begin
                    o_ctrl.SR1sel  = 1'b1;
                    o_ctrl.gateALU = 1'b1;
                    o_ctrl.ldREG   = 1'b1;
                    o_ctrl.ldCC    = 1'b1;
                    case (w_op)
                        OP_AND:  o_ctrl.aluK = ALUK_AND;
                        OP_NOT:  o_ctrl.aluK = ALUK_NOT;
                        default: o_ctrl.aluK = ALUK_ADD;
                    endcase
                end
                S_BR: begin
                    o_ctrl.selEAB1 = 1'b0;
                    o_ctrl.selEAB2 = EAB2_OFF9;
                    o_ctrl.selPC   = SELPC_EAB;
                    o_ctrl.ldPC    = (i_ir_hi[11] & i_n) | (i_ir_hi[10] & i_z) | (i_ir_hi[9] & i_p);
                end
                S_JMP: begin
                    o_ctrl.SR1sel  = 1'b1;
                    o_ctrl.aluK    = ALUK_PASSA;
                    o_ctrl.gateALU = 1'b1;
                    o_ctrl.selPC   = SELPC_BUS;
                    o_ctrl.ldPC    = 1'b1;
                end
                S_LEA: begin
                    o_ctrl.selEAB1    = 1'b0;
                    o_ctrl.selEAB2    = EAB2_OFF9;
                    o_ctrl.gateMARMUX = 1'b1;
                    o_ctrl.ldREG      = 1'b1;
                    o_ctrl.ldCC       = 1'b1;
                end
                S_ADDR: begin
                    o_ctrl.gateMARMUX = 1'b1;
                    o_ctrl.ldMAR      = 1'b1;
                    // Register-relative forms use Ra + offset6, others PC + offset9
                    if (w_op == OP_LDR || w_op == OP_STR) begin
                        o_ctrl.selEAB1 = 1'b1;
                        o_ctrl.selEAB2 = EAB2_OFF6;
                    end else begin
                        o_ctrl.selEAB1 = 1'b0;
                        o_ctrl.selEAB2 = EAB2_OFF9;
                    end
                end
                S_LOADREG: begin
                    o_ctrl.gateMDR = 1'b1;
                    o_ctrl.ldREG   = 1'b1;
                    o_ctrl.ldCC    = 1'b1;
                end
                S_STMDR: begin
                    o_ctrl.SR1sel  = 1'b0;
                    o_ctrl.aluK    = ALUK_PASSA;
                    o_ctrl.gateALU = 1'b1;
                    o_ctrl.ldMDR   = 1'b1;
                end
                S_MEMWR: begin
                    o_ctrl.memEn = 1'b1;
                    o_ctrl.memWE = 1'b1;
                end
                S_HALT: o_ctrl.halted = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/lc3_control.sv
// Purpose : LC-3 multi-cycle control FSM (fetch/decode/execute) driving datapath and memory handshake.
// Latency : 5 cycles for ALU/BR/JMP/LEA, 7 for loads/stores, +1 per memory wait cycle.
// Backpressure: memory states hold until memReady; unsupported opcode parks in HALT until reset.
// Ports   : clk, rst (async active-low), bus (lc3_control_if.master: IR/NZP/memReady in, controls out).
module lc3_control
    import lc3_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    lc3_control_if.master bus
);
    logic [3:0] r_state;
    logic [3:0] w_next;
    logic [3:0] w_op;
    ctrl_t      w_ctrl;
    logic       w_unused_ir;

    assign w_op        = bus.IR[15:12];
    assign w_unused_ir = &{1'b0, bus.IR[8:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH0;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH0: w_next = S_FETCH1;
            S_FETCH1: if (bus.memReady) w_next = S_FETCH2;
            S_FETCH2: w_next = S_DECODE;
            S_DECODE: begin
                case (w_op)
                    OP_ADD, OP_AND, OP_NOT:         w_next = S_EXEC_ALU;
                    OP_BR:                          w_next = S_BR;
                    OP_JMP:                         w_next = S_JMP;
                    OP_LEA:                         w_next = S_LEA;
                    OP_LD, OP_ST, OP_LDR, OP_STR:   w_next = S_ADDR;
                    default:                        w_next = S_HALT;
                endcase
            end
            S_EXEC_ALU, S_BR, S_JMP, S_LEA, S_LOADREG: w_next = S_FETCH0;
            S_ADDR:   w_next = is_load(w_op) ? S_MEMRD : S_STMDR;
            S_MEMRD:  if (bus.memReady) w_next = S_LOADREG;
            S_STMDR:  w_next = S_MEMWR;
            S_MEMWR:  if (bus.memReady) w_next = S_FETCH0;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_FETCH0;
        endcase
    end

    lc3_ctrl_decode u_decode (
        .i_rst_n     (rst),
        .i_state     (r_state),
        .i_ir_hi     (bus.IR[15:9]),
        .i_n         (bus.N),
        .i_z         (bus.Z),
        .i_p         (bus.P),
        .i_mem_ready (bus.memReady),
        .o_ctrl      (w_ctrl)
    );

    assign bus.ldMAR      = w_ctrl.ldMAR;
    assign bus.ldMDR      = w_ctrl.ldMDR;
    assign bus.ldIR       = w_ctrl.ldIR;
    assign bus.ldPC       = w_ctrl.ldPC;
    assign bus.ldREG      = w_ctrl.ldREG;
    assign bus.ldCC       = w_ctrl.ldCC;
    assign bus.gatePC     = w_ctrl.gatePC;
    assign bus.gateMDR    = w_ctrl.gateMDR;
    assign bus.gateALU    = w_ctrl.gateALU;
    assign bus.gateMARMUX = w_ctrl.gateMARMUX;
    assign bus.selPC      = w_ctrl.selPC;
    assign bus.selEAB1    = w_ctrl.selEAB1;
    assign bus.selEAB2    = w_ctrl.selEAB2;
    assign bus.SR1sel     = w_ctrl.SR1sel;
    assign bus.aluK       = w_ctrl.aluK;
    assign bus.memEn      = w_ctrl.memEn;
    assign bus.memWE      = w_ctrl.memWE;
    assign bus.halted     = w_ctrl.halted;
endmodule

// File: tb/tb_lc3_control.sv
// Purpose : directed self-checking bench for lc3_control.
// Latency : n/a.
// Backpressure: memReady driven per cycle by the bench to create wait states.
module tb_lc3_control;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lc3_control_if bus ();
    lc3_control dut (.clk(clk), .rst(rst), .bus(bus));

    int n_chk  = 0;
    int n_pass = 0;

    // Control word bit order: ldMAR ldMDR ldIR ldPC ldREG ldCC gatePC gateMDR gateALU
    // gateMARMUX selPC[1:0] selEAB1 selEAB2[1:0] SR1sel aluK[1:0] memEn memWE halted
    localparam logic [20:0] V_FETCH0 = 21'h124000; // ldMAR|ldPC|gatePC
    localparam logic [20:0] V_STMDR  = 21'h081018; // ldMDR|gateALU|aluK=11
    localparam logic [20:0] V_LEA    = 21'h018880; // ldREG|ldCC|gateMARMUX|selEAB2=10

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [20:0] outs();
        return {bus.ldMAR, bus.ldMDR, bus.ldIR, bus.ldPC, bus.ldREG, bus.ldCC,
                bus.gatePC, bus.gateMDR, bus.gateALU, bus.gateMARMUX,
                bus.selPC, bus.selEAB1, bus.selEAB2, bus.SR1sel, bus.aluK,
                bus.memEn, bus.memWE, bus.halted};
    endfunction

    function automatic logic [5:0] loads();
        return {bus.ldMAR, bus.ldMDR, bus.ldIR, bus.ldPC, bus.ldREG, bus.ldCC};
    endfunction

    // Advance one clock; drive memReady for the new cycle, settle before checking.
    task automatic step(input logic rdy);
        @(negedge clk);
        bus.memReady = rdy;
        #1;
    endtask

    // Called during a FETCH0 cycle; leaves the bench in the DECODE cycle.
    task automatic fetch(input logic [15:0] ir);
        bus.IR = ir;
        #1;
        chk("fetch0_word", outs(), V_FETCH0);
        step(1'b1);
        chk("fetch1_loads", loads(), 6'b010000);
        chk("fetch1_memen", bus.memEn, 1'b1);
        step(1'b1);
        chk("fetch2_loads", loads(), 6'b001000);
        chk("fetch2_gatemdr", bus.gateMDR, 1'b1);
        step(1'b1);
        chk("decode_idle", outs(), 21'h0);
    endtask

    initial begin
        int en_cnt;
        rst = 1'b0;
        bus.IR = 16'h12A3;
        bus.N = 1'b0; bus.Z = 1'b0; bus.P = 1'b0;
        bus.memReady = 1'b1;
        #2;
        chk("reset_all_zero", outs(), 21'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;

        // ADD: result written only in cycle 5, FETCH0 again in cycle 6
        fetch(16'h12A3);
        step(1'b1);
        chk("add_loads", loads(), 6'b000011);
        chk("add_aluk", bus.aluK, 2'b00);
        chk("add_gatealu", bus.gateALU, 1'b1);
        chk("add_sr1sel", bus.SR1sel, 1'b1);
        step(1'b1);
        chk("add_back_fetch0", outs(), V_FETCH0);

        fetch(16'h5283); step(1'b1);
        chk("and_aluk", bus.aluK, 2'b01);
        step(1'b1);
        fetch(16'h923F); step(1'b1);
        chk("not_aluk", bus.aluK, 2'b10);
        step(1'b1);

        // BR nzp=111, Z set -> taken; flags act within the cycle
        bus.Z = 1'b1;
        fetch(16'h0E05); step(1'b1);
        chk("br_ldpc_taken", bus.ldPC, 1'b1);
        chk("br_selpc", bus.selPC, 2'b01);
        chk("br_seleab1", bus.selEAB1, 1'b0);
        chk("br_seleab2", bus.selEAB2, 2'b10);
        bus.Z = 1'b0; #1;
        chk("br_noflags_ldpc", bus.ldPC, 1'b0);
        step(1'b1);
        // BRz with Z=0, N=1 -> not taken, then Z rises mid-cycle
        bus.N = 1'b1;
        fetch(16'h0405); step(1'b1);
        chk("brz_not_taken", bus.ldPC, 1'b0);
        bus.Z = 1'b1; #1;
        chk("brz_comb_taken", bus.ldPC, 1'b1);
        bus.Z = 1'b0; bus.N = 1'b0;
        step(1'b1);

        // JMP
        fetch(16'hC1C0); step(1'b1);
        chk("jmp_ldpc", bus.ldPC, 1'b1);
        chk("jmp_selpc", bus.selPC, 2'b10);
        chk("jmp_aluk", bus.aluK, 2'b11);
        chk("jmp_sr1sel", bus.SR1sel, 1'b1);
        step(1'b1);

        // LDR with three wait cycles in MEMRD
        fetch(16'h673F); step(1'b1);
        chk("ldr_addr_seleab1", bus.selEAB1, 1'b1);
        chk("ldr_addr_seleab2", bus.selEAB2, 2'b01);
        chk("ldr_addr_loads", loads(), 6'b100000);
        chk("ldr_addr_gatemarmux", bus.gateMARMUX, 1'b1);
        en_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            step(i == 3);
            en_cnt += int'(bus.memEn);
            chk("ldr_memrd_ldmdr", bus.ldMDR, (i == 3));
        end
        chk("ldr_memen_cycles", en_cnt, 4);
        step(1'b1);
        chk("ldr_loadreg_loads", loads(), 6'b000011);
        chk("ldr_loadreg_gatemdr", bus.gateMDR, 1'b1);
        step(1'b1);
        chk("ldr_back_fetch0", outs(), V_FETCH0);

        // ST with two wait cycles in MEMWR
        fetch(16'h3A02); step(1'b1);
        chk("st_addr_seleab1", bus.selEAB1, 1'b0);
        chk("st_addr_seleab2", bus.selEAB2, 2'b10);
        step(1'b1);
        chk("st_stmdr_word", outs(), V_STMDR);
        step(1'b0);
        chk("st_memwr_w0", {bus.memEn, bus.memWE}, 2'b11);
        step(1'b0);
        chk("st_memwr_w1", {bus.memEn, bus.memWE}, 2'b11);
        step(1'b1);
        chk("st_memwr_done", {bus.memEn, bus.memWE}, 2'b11);
        step(1'b1);
        chk("st_back_fetch0", outs(), V_FETCH0);

        // LEA
        fetch(16'hE1FF); step(1'b1);
        chk("lea_word", outs(), V_LEA);
        step(1'b1);

        // LD, reset asserted while waiting in MEMRD
        fetch(16'h2205); step(1'b1);
        step(1'b0);
        chk("ld_memrd_memen", bus.memEn, 1'b1);
        rst = 1'b0; #1;
        chk("rst_mid_memrd_zero", outs(), 21'h0);
        step(1'b1);
        chk("rst_held_zero", outs(), 21'h0);
        rst = 1'b1; #1;
        chk("rst_release_fetch0", outs(), V_FETCH0);

        // Unsupported opcode parks in HALT
        fetch(16'hF025); step(1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("halt_flag", bus.halted, 1'b1);
            chk("halt_no_loads", loads(), 6'b000000);
            chk("halt_no_mem", bus.memEn, 1'b0);
            step(i[0]);
        end
        rst = 1'b0; #1;
        chk("halt_rst_zero", outs(), 21'h0);
        step(1'b1);
        rst = 1'b1; #1;
        chk("halt_rst_fetch0", outs(), V_FETCH0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lc3_control.md
# lc3_control

Multi-cycle control unit for the LC-3 datapath. It sequences fetch, decode and execute for the base instruction subset by driving the load enables, bus gates and mux selects of the register file, ALU, EAB, PC, MAR/MDR and IR. It also runs a ready/enable handshake with the memory. It sits beside the datapath top and is the only source of `selEAB1`/`selEAB2` for the effective-address block.

## Interface
- No parameters. All encodings are fixed in `lc3_pkg`.
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: asynchronous reset, active-low.
- `IR` in 16: current instruction register contents.
- `N`, `Z`, `P` in 1 each: condition-code flags.
- `memReady` in 1: memory has completed the current access.
- `ldMAR`, `ldMDR`, `ldIR`, `ldPC`, `ldREG`, `ldCC` out 1 each: register load enables.
- `gatePC`, `gateMDR`, `gateALU`, `gateMARMUX` out 1 each: bus drivers, one-hot or all zero.
- `selPC` out 2: PC mux select. 00 = PC+1, 01 = eabOut, 10 = bus.
- `selEAB1` out 1: EAB base select. 0 = PC, 1 = Ra.
- `selEAB2` out 2: EAB offset select. 00 = 0, 01 = sext IR[5:0], 10 = sext IR[8:0], 11 = sext IR[10:0].
- `SR1sel` out 1: SR1 field select. 0 = IR[11:9], 1 = IR[8:6].
- `aluK` out 2: ALU function. 00 = ADD, 01 = AND, 10 = NOT, 11 = PASSA.
- `memEn`, `memWE` out 1 each: memory request and write strobe.
- `halted` out 1: control unit is stopped on an unsupported opcode.

## Operation
- States: FETCH0, FETCH1, FETCH2, DECODE, EXEC_ALU, BR, JMP, LEA, ADDR, MEMRD, LOADREG, STMDR, MEMWR, HALT.
- FETCH0:
  - Asserts `gatePC`, `ldMAR`, `ldPC`, `selPC=00`.
  - Next state is FETCH1.
- FETCH1:
  - Asserts `memEn`; `ldMDR` = `memReady`.
  - Stays in FETCH1 until `memReady`=1, then goes to FETCH2.
- FETCH2:
  - Asserts `gateMDR`, `ldIR`.
  - Next state is DECODE.
- DECODE: outputs idle. Branches on IR[15:12]:
  - ADD/AND/NOT go to EXEC_ALU.
  - BR goes to BR.
  - JMP goes to JMP.
  - LEA goes to LEA.
  - LD/ST/LDR/STR go to ADDR.
  - Any other opcode goes to HALT.
- EXEC_ALU:
  - Asserts `SR1sel=1`, `gateALU`, `ldREG`, `ldCC`.
  - `aluK` = 00 for ADD, 01 for AND, 10 for NOT.
  - Next state is FETCH0.
- BR:
  - Drives `selEAB1=0`, `selEAB2=10`, `selPC=01`.
  - `ldPC` = (IR[11]&N) | (IR[10]&Z) | (IR[9]&P).
  - Next state is FETCH0.
- JMP:
  - Asserts `SR1sel=1`, `aluK=11`, `gateALU`, `selPC=10`, `ldPC`.
  - Next state is FETCH0.
- LEA:
  - Drives `selEAB1=0`, `selEAB2=10`, `gateMARMUX`, `ldREG`, `ldCC`.
  - Next state is FETCH0.
- ADDR:
  - Asserts `gateMARMUX` and `ldMAR`.
  - LD/ST drive `selEAB1=0`, `selEAB2=10`.
  - LDR/STR drive `selEAB1=1`, `selEAB2=01`.
  - Loads go to MEMRD; stores go to STMDR.
- MEMRD:
  - Asserts `memEn`; `ldMDR` = `memReady`.
  - Stays until `memReady`=1, then goes to LOADREG.
- LOADREG:
  - Asserts `gateMDR`, `ldREG`, `ldCC`.
  - Next state is FETCH0.
- STMDR:
  - Asserts `SR1sel=0`, `aluK=11`, `gateALU`, `ldMDR`.
  - Next state is MEMWR.
- MEMWR:
  - Asserts `memEn`, `memWE`.
  - Stays until `memReady`=1, then goes to FETCH0.
- HALT:
  - Drives `halted=1`; all other outputs 0.
  - Only reset leaves HALT.
- In every state, any output not listed above is 0.

## Timing
- `rst` low:
  - State is forced to FETCH0 immediately.
  - All outputs are 0 combinationally, including those FETCH0 would otherwise drive.
  - The first FETCH0 loads happen on the first rising edge after `rst` rises.
- Reset in the middle of an operation (e.g. during MEMRD) drops `memEn` in the same cycle. No partial load is committed.
- Outputs are a decode of the current state, IR and flags. There is no output register.
- `memReady` and NZP act combinationally within the cycle.
- Memory handshake:
  - `memEn` stays high continuously until the edge on which `memReady`=1 is sampled.
  - `memReady` asserted in the first wait cycle gives zero wait states.
  - `memReady` outside FETCH1/MEMRD/MEMWR is ignored.
- Latency with zero wait states:
  - ALU, BR, JMP, LEA: 5 cycles.
  - LD, LDR, ST, STR: 7 cycles.
  - Each memory wait cycle adds 1.

## Structure
- `lc3_pkg` holds:
  - opcode constants;
  - the state enumeration;
  - encodings for `selPC`, `selEAB2` and `aluK`.
- Sub-module `lc3_ctrl_decode` holds the combinational output decode from (state, IR, NZP, `memReady`).
- `lc3_control` holds the state register and next-state logic.

## Test plan
- ADD, IR=16'h12A3, `memReady`=1 after reset:
  - Visits FETCH0, FETCH1, FETCH2, DECODE, EXEC_ALU.
  - `ldREG`=`ldCC`=1 with `aluK`=00 only in cycle 5.
  - FETCH0 in cycle 6.
- BR, IR=16'h0E05:
  - `ldPC`=1, `selPC`=01, `selEAB1`=0, `selEAB2`=10.
  - With IR=16'h0405 and Z=0, `ldPC`=0.
- LDR, IR=16'h673F, `memReady` low for 3 MEMRD cycles:
  - ADDR drives `selEAB1`=1, `selEAB2`=01.
  - `memEn`=1 for 4 cycles.
  - `ldMDR` is high only in the last of those cycles.
  - LOADREG asserts `ldREG`.
- ST, IR=16'h3A02:
  - STMDR drives `SR1sel`=0, `aluK`=11, `ldMDR`=1.
  - MEMWR holds `memEn`=`memWE`=1 until `memReady`, then returns to FETCH0.
- LEA, IR=16'hE1FF: `gateMARMUX`=`ldREG`=`ldCC`=1 with `selEAB2`=10.
- Halt and reset:
  - IR=16'hF025 goes to HALT; `halted`=1 and no load asserts for 10 cycles.
  - `rst` pulsed low during MEMRD zeroes all outputs immediately.
  - After release, the bench resumes at FETCH0.
